// File: rtl/i_ddr_gearbox.sv
// DDR-pair to WIDTH-bit deserializing gearbox with bitslip and optional auto-align (I_DDR_GEARBOX_ALIGN_EN).
// Latency: Q/VALID registered, VALID one cycle after the append that completes a word.
// Backpressure: none; E=0 freezes all datapath state, and every enabled pair is consumed.
module i_ddr_gearbox #(
    parameter int unsigned WIDTH         = 8,
    parameter logic [15:0] ALIGN_PATTERN = 16'h00A5,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic [1:0]       D,
    input  logic             E,
    input  logic             BITSLIP,
    input  logic             ALIGN_START,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             LOCKED
);

    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_W  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_W1 = CW'(WIDTH + 1);

    // Holding register only needs WIDTH bits: before any append at most WIDTH-1 bits are live.
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH:0]   sr_app;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_app;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             slip_q, slip_d;
    logic             slip_req;

    // Append the enabled pair (or only D[0] on a pending slip) and peel off a full word.
    always_comb begin
        sr_app  = {1'b0, sr_q};
        cnt_app = cnt_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = 1'b0;
        if (E) begin
            if (slip_q) begin
                sr_app  = {sr_q, D[0]};
                cnt_app = cnt_q + CW'(1);
            end else begin
                sr_app  = {sr_q[WIDTH-2:0], D};
                cnt_app = cnt_q + CW'(2);
            end
            sr_d  = sr_app[WIDTH-1:0];
            cnt_d = cnt_app;
            if (cnt_app >= CNT_W) begin
                valid_d = 1'b1;
                cnt_d   = cnt_app - CNT_W;
                q_d     = (cnt_app == CNT_W1) ? sr_app[WIDTH:1] : sr_app[WIDTH-1:0];
            end
        end
        // A pending slip is consumed by the next enabled cycle; new requests while pending are dropped.
        slip_d = (slip_q & ~E) | (slip_req & ~slip_q);
    end

    // Datapath registers; reset discards any partial word.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            slip_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            slip_q  <= slip_d;
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;

`ifdef I_DDR_GEARBOX_ALIGN_EN
    typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_CHECK, ST_LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state_q, state_d;
    logic [3:0] match_q, match_d;
    logic [1:0] settle_q, settle_d;
    logic       int_slip;
    logic       q_match;

    assign q_match = (q_q == ALIGN_PATTERN[WIDTH-1:0]);

    // Auto-align: slip one bit per mismatching word, let two words settle, then require LOCK_N hits.
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        settle_d = settle_q;
        int_slip = 1'b0;
        if (ALIGN_START) begin
            state_d  = ST_HUNT;
            match_d  = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (valid_q) begin
                        if (settle_q != 2'd0) begin
                            settle_d = settle_q - 2'd1;
                        end else if (q_match) begin
                            match_d = 4'd1;
                            state_d = (LOCK_N == 4'd1) ? ST_LOCKED : ST_CHECK;
                        end else begin
                            int_slip = 1'b1;
                            settle_d = 2'd2;
                        end
                    end
                end
                ST_CHECK: begin
                    if (valid_q) begin
                        if (q_match) begin
                            match_d = match_q + 4'd1;
                            if (match_q + 4'd1 == LOCK_N) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            match_d = '0;
                            state_d = ST_HUNT;
                        end
                    end
                end
                ST_IDLE, ST_LOCKED: begin
                    state_d = state_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Align FSM registers.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q  <= ST_IDLE;
            match_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            settle_q <= settle_d;
        end
    end

    // While hunting/checking the FSM owns the slip request; external BITSLIP only counts otherwise.
    assign slip_req = (state_q == ST_HUNT || state_q == ST_CHECK) ? int_slip : BITSLIP;
    assign LOCKED   = (state_q == ST_LOCKED);
`else
    logic unused_align_start;

    assign unused_align_start = ALIGN_START;
    assign slip_req           = BITSLIP;
    assign LOCKED             = 1'b0;
`endif

endmodule
